prog_rom_loadable: RTL and testbench

- Parametrised instruction memory, next generation of the fixed 32-word combinational program ROM.
- Adds a registered fetch port with a req/valid handshake, plus a sequential loader port so programs are written at run time instead of fixed at elaboration.
- Sits between the program counter / fetch stage and the instruction decoder. The loader is driven by the test bench or a boot controller.

---
 rtl/prog_rom_loadable_if.sv | 52 +++++
 rtl/prog_rom_loadable.sv | 147 ++++++++++++++
 tb/tb_prog_rom_loadable.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_rom_loadable_if.sv
// Fetch/loader bundle between the fetch stage (master) and the instruction memory (slave).
// Latency: none, wires only.
// Backpressure: fetch_busy refuses fetches while a load runs; the loader stalls whenever load_wr is low.
// Signals:
//   fetch_req/fetch_addr -> fetch_data/fetch_valid/fetch_busy
//   load_start/load_base/load_count/load_wr/load_data -> load_done
// Optional signals under PROG_ROM_PARITY_EN:
//   inj_perr (to memory) and fetch_perr (from memory).
interface prog_rom_loadable_if #(
    parameter int ADDR_WIDTH  = 5,
    parameter int INSTR_WIDTH = 8
);
    logic                   fetch_req;
    logic [ADDR_WIDTH-1:0]  fetch_addr;
    logic [INSTR_WIDTH-1:0] fetch_data;
    logic                   fetch_valid;
    logic                   fetch_busy;
    logic                   load_start;
    logic [ADDR_WIDTH-1:0]  load_base;
    logic [ADDR_WIDTH:0]    load_count;
    logic                   load_wr;
    logic [INSTR_WIDTH-1:0] load_data;
    logic                   load_done;
`ifdef PROG_ROM_PARITY_EN
    logic                   inj_perr;
    logic                   fetch_perr;

    modport master (
        output fetch_req, fetch_addr, load_start, load_base, load_count,
               load_wr, load_data, inj_perr,
        input  fetch_data, fetch_valid, fetch_busy, load_done, fetch_perr
    );

    modport slave (
        input  fetch_req, fetch_addr, load_start, load_base, load_count,
               load_wr, load_data, inj_perr,
        output fetch_data, fetch_valid, fetch_busy, load_done, fetch_perr
    );
`else
    modport master (
        output fetch_req, fetch_addr, load_start, load_base, load_count,
               load_wr, load_data,
        input  fetch_data, fetch_valid, fetch_busy, load_done
    );

    modport slave (
        input  fetch_req, fetch_addr, load_start, load_base, load_count,
               load_wr, load_data,
        output fetch_data, fetch_valid, fetch_busy, load_done
    );
`endif
endinterface

// File: rtl/prog_rom_loadable.sv
// Run-time loadable instruction memory with a registered fetch port and a sequential loader.
// Latency: fetch data/valid one cycle after an accepted request; load_done one cycle after the final write.
// Backpressure: fetches are refused (fetch_busy) while the loader is in LOAD or DONE; loader waits on load_wr.
// Ports:
//   clk, rst         : single clock, synchronous active-high reset
//   bus (slave)      : fetch_req/fetch_addr in, fetch_data/fetch_valid/fetch_busy out,
//                      load_start/load_base/load_count/load_wr/load_data in, load_done out
// Optional: define PROG_ROM_PARITY_EN to store an even-parity bit per word, adding
//   inj_perr (in, inverts the stored parity on a load write) and fetch_perr (out).
module prog_rom_loadable #(
    parameter int                     ADDR_WIDTH  = 5,
    parameter int                     INSTR_WIDTH = 8,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0
) (
    input  logic               clk,
    input  logic               rst,
    prog_rom_loadable_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef PROG_ROM_PARITY_EN
    localparam int                WORD_W    = INSTR_WIDTH + 1;
    localparam logic [WORD_W-1:0] INIT_WORD = {^NOP_WORD, NOP_WORD};
`else
    localparam int                WORD_W    = INSTR_WIDTH;
    localparam logic [WORD_W-1:0] INIT_WORD = NOP_WORD;
`endif

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   REM_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   ptr, ptr_nxt;
    logic [ADDR_WIDTH:0]     remain, remain_nxt;
    logic                    mem_we;
    logic [WORD_W-1:0]       wr_word;
    logic [WORD_W-1:0]       rd_word;
    logic                    fetch_acc;
    logic [INSTR_WIDTH-1:0]  fetch_data_q;
    logic                    fetch_valid_q;

    // Contents survive rst by design; only power-up sets them to NOP.
    logic [WORD_W-1:0] mem [DEPTH] = '{default: INIT_WORD};

    // ---------------- loader FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            remain <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            remain <= remain_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        remain_nxt = remain;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load_start) begin
                    if (bus.load_count != '0) begin
                        state_nxt  = LOAD;
                        ptr_nxt    = bus.load_base;
                        remain_nxt = bus.load_count;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            LOAD: begin
                if (bus.load_wr) begin
                    mem_we     = 1'b1;
                    ptr_nxt    = ptr + PTR_ONE;   // wraps modulo depth
                    remain_nxt = remain - REM_ONE;
                    if (remain == REM_ONE) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- memory ----------------
`ifdef PROG_ROM_PARITY_EN
    assign wr_word = {(^bus.load_data) ^ bus.inj_perr, bus.load_data};
`else
    assign wr_word = bus.load_data;
`endif

    // A write coinciding with rst is dropped so a reset cleanly aborts the load.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[ptr] <= wr_word;
        end
    end

    // Fetch is only accepted in IDLE, so the read never collides with a load write.
    assign rd_word   = mem[bus.fetch_addr];
    assign fetch_acc = bus.fetch_req && (state == IDLE);

    // ---------------- fetch port ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_data_q  <= NOP_WORD;
            fetch_valid_q <= 1'b0;
        end else begin
            fetch_valid_q <= fetch_acc;
            if (fetch_acc) begin
                fetch_data_q <= rd_word[INSTR_WIDTH-1:0];
            end
        end
    end

`ifdef PROG_ROM_PARITY_EN
    logic fetch_perr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_perr_q <= 1'b0;
        end else if (fetch_acc) begin
            fetch_perr_q <= rd_word[INSTR_WIDTH] ^ (^rd_word[INSTR_WIDTH-1:0]);
        end
    end

    assign bus.fetch_perr = fetch_perr_q;
`endif

    assign bus.fetch_data  = fetch_data_q;
    assign bus.fetch_valid = fetch_valid_q;
    // state is itself a register, so this is a clean registered view.
    assign bus.fetch_busy  = (state != IDLE);
    assign bus.load_done   = (state == DONE);

endmodule

// File: tb/tb_prog_rom_loadable.sv
// Directed bench for prog_rom_loadable: fetch expectations go into a queue, a negedge monitor
// pops and compares each presented word; loader and reset behaviour are checked inline.
module tb_prog_rom_loadable;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prog_rom_loadable_if #(.ADDR_WIDTH(5), .INSTR_WIDTH(8)) bus ();

    prog_rom_loadable #(
        .ADDR_WIDTH (5),
        .INSTR_WIDTH(8),
        .NOP_WORD   (8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         done_before = 0;
    logic [7:0] last_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: consumes one expectation per cycle that presents fetch_valid.
    always @(negedge clk) begin
        exp_t e;
        if (bus.load_done === 1'b1) done_cnt++;
        if (bus.fetch_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data %0h, expected no valid", bus.fetch_data);
            end else begin
                e = exp_q.pop_front();
                check("fetch_data", 32'(bus.fetch_data), 32'(e.data));
`ifdef PROG_ROM_PARITY_EN
                check("fetch_perr", 32'(bus.fetch_perr), 32'(e.perr));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one(input logic [4:0] addr, input logic [7:0] exp, input logic perr);
        exp_t e;
        e.data = exp;
        e.perr = perr;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        exp_q.push_back(e);
        last_data = exp;
        step();
        bus.fetch_req = 1'b0;
    endtask

    task automatic drain(input string name);
        step();
        step();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic load_begin(input logic [4:0] base, input logic [5:0] count);
        done_before     = done_cnt;
        bus.load_start  = 1'b1;
        bus.load_base   = base;
        bus.load_count  = count;
        step();
        bus.load_start  = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] d, input bit gap, input logic inj);
        if (gap) step();
        bus.load_wr   = 1'b1;
        bus.load_data = d;
`ifdef PROG_ROM_PARITY_EN
        bus.inj_perr  = inj;
`else
        if (inj) bus.load_data = d;
`endif
        step();
        bus.load_wr = 1'b0;
`ifdef PROG_ROM_PARITY_EN
        bus.inj_perr = 1'b0;
`endif
    endtask

    // Called in the cycle right after the final write edge (the DONE cycle).
    task automatic load_end(input string name);
        check({name, "_busy_in_done"}, 32'(bus.fetch_busy), 32'd1);
        check({name, "_done_not_early"}, 32'(done_cnt - done_before), 32'd0);
        step();
        check({name, "_done_pulse"}, 32'(done_cnt - done_before), 32'd1);
        check({name, "_busy_clear"}, 32'(bus.fetch_busy), 32'd0);
        step();
        check({name, "_done_single"}, 32'(done_cnt - done_before), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_count = '0;
        bus.load_wr    = 1'b0;
        bus.load_data  = '0;
`ifdef PROG_ROM_PARITY_EN
        bus.inj_perr   = 1'b0;
`endif
        step();
        step();
        check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        check("rst_fetch_data", 32'(bus.fetch_data), 32'h00);
        check("rst_fetch_busy", 32'(bus.fetch_busy), 32'd0);
        check("rst_load_done", 32'(bus.load_done), 32'd0);
`ifdef PROG_ROM_PARITY_EN
        check("rst_fetch_perr", 32'(bus.fetch_perr), 32'd0);
`endif
        rst = 1'b0;

        // Power-up contents: every word is NOP, back-to-back fetches.
        for (int a = 0; a < 32; a++) fetch_one(5'(a), 8'h00, 1'b0);
        drain("powerup_drain");

        // Load 4 words at base 3 with idle gaps between writes.
        load_begin(5'd3, 6'd4);
        load_word(8'h11, 1'b1, 1'b0);
        load_word(8'h22, 1'b1, 1'b0);
        load_word(8'h33, 1'b1, 1'b0);
        load_word(8'h44, 1'b1, 1'b0);
        load_end("load4");
        fetch_one(5'd2, 8'h00, 1'b0);
        fetch_one(5'd3, 8'h11, 1'b0);
        fetch_one(5'd4, 8'h22, 1'b0);
        fetch_one(5'd5, 8'h33, 1'b0);
        fetch_one(5'd6, 8'h44, 1'b0);
        fetch_one(5'd7, 8'h00, 1'b0);
        drain("load4_drain");

        // Pointer wrap from 31 to 0.
        load_begin(5'd30, 6'd4);
        load_word(8'hA1, 1'b0, 1'b0);
        load_word(8'hA2, 1'b0, 1'b0);
        load_word(8'hA3, 1'b0, 1'b0);
        load_word(8'hA4, 1'b0, 1'b0);
        load_end("wrap");
        fetch_one(5'd29, 8'h00, 1'b0);
        fetch_one(5'd30, 8'hA1, 1'b0);
        fetch_one(5'd31, 8'hA2, 1'b0);
        fetch_one(5'd0,  8'hA3, 1'b0);
        fetch_one(5'd1,  8'hA4, 1'b0);
        fetch_one(5'd2,  8'h00, 1'b0);
        drain("wrap_drain");

        // Fetch refused while loading: valid stays low and data holds (last was 0x00).
        load_begin(5'd16, 6'd2);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 5'd3;
        step();
        bus.fetch_req  = 1'b0;
        check("blocked_valid", 32'(bus.fetch_valid), 32'd0);
        check("blocked_data_hold", 32'(bus.fetch_data), 32'(last_data));
        check("blocked_busy", 32'(bus.fetch_busy), 32'd1);
        load_word(8'h77, 1'b0, 1'b0);
        load_word(8'h88, 1'b0, 1'b0);
        load_end("blocked");
        fetch_one(5'd16, 8'h77, 1'b0);
        fetch_one(5'd17, 8'h88, 1'b0);
        drain("blocked_drain");

        // Zero-length load: DONE straight away, nothing written.
        load_begin(5'd3, 6'd0);
        load_end("zero");
        fetch_one(5'd3, 8'h11, 1'b0);
        fetch_one(5'd0, 8'hA3, 1'b0);
        drain("zero_drain");

        // Fetch accepted on the load_start edge sees the old word.
        done_before    = done_cnt;
        bus.load_start = 1'b1;
        bus.load_base  = 5'd3;
        bus.load_count = 6'd1;
        fetch_one(5'd3, 8'h11, 1'b0);
        bus.load_start = 1'b0;
        load_word(8'h99, 1'b0, 1'b0);
        load_end("same_edge");
        fetch_one(5'd3, 8'h99, 1'b0);
        drain("same_edge_drain");

        // Reset in the middle of a load.
        load_begin(5'd8, 6'd4);
        load_word(8'h55, 1'b0, 1'b0);
        load_word(8'h66, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 32'(bus.fetch_busy), 32'd0);
        step();
        step();
        check("midrst_no_done", 32'(done_cnt - done_before), 32'd0);
        fetch_one(5'd8,  8'h55, 1'b0);
        fetch_one(5'd9,  8'h66, 1'b0);
        fetch_one(5'd10, 8'h00, 1'b0);
        drain("midrst_drain");

        // Full-depth load from base 20 rewrites every word.
        load_begin(5'd20, 6'd32);
        for (int i = 0; i < 32; i++) load_word(8'(8'hC0 + i), 1'b0, 1'b0);
        load_end("full");
        for (int a = 0; a < 32; a++) fetch_one(5'(a), 8'(8'hC0 + ((a + 12) % 32)), 1'b0);
        drain("full_drain");

        // Parity injection at address 5 (data check only without the parity build).
        load_begin(5'd5, 6'd1);
        load_word(8'h7E, 1'b0, 1'b1);
        load_end("parity");
        fetch_one(5'd5, 8'h7E, 1'b1);
        fetch_one(5'd4, 8'hD0, 1'b0);
        drain("parity_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
